button_conditioner: RTL and testbench
=====================================

# button_conditioner

Multi-channel button input conditioner. It is the parametrised successor of the single-button debouncer. Each of CHANNELS raw inputs gets a 2-flop synchroniser, a counter-based debounce filter, one-cycle press/release event pulses and a long-press detector. It sits between the board pins and the control FSMs, which consume only clean levels and single-cycle events.

## Interface
- CHANNELS, 4: number of independent button channels.
- COUNT_MAX, 19999: debounce threshold; a change is accepted after COUNT_MAX+1 consecutive differing samples.
- CNT_W, 16: debounce counter width; COUNT_MAX < 2**CNT_W is required.
- LONG_MAX, 50000000: cycles of debounced press before long_press fires; ≥1; LONG_MAX < 2**HOLD_W is required.
- HOLD_W, 26: hold counter width.
- ACTIVE_LOW, 1: 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- button_in  input  CHANNELS  raw, asynchronous button pins.
- level  output  CHANNELS  debounced state, 1 = pressed.
- press  output  CHANNELS  one-cycle pulse on debounced press.
- release  output  CHANNELS  one-cycle pulse on debounced release.
- long_press  output  CHANNELS  one-cycle pulse once per press when held LONG_MAX cycles.

## Operation
- Channels are fully independent. No shared state other than clk and rst_n.
- Internal pressed sense p = ACTIVE_LOW ? ~button_in[i] : button_in[i].
- Synchroniser: s1 <= p; s2 <= s1. Reset value is 0 (released).
- Debounce, per edge:
  - if s2 != level: cnt <= cnt+1.
  - if additionally cnt == COUNT_MAX: level <= s2, cnt <= 0.
  - if s2 == level: cnt <= 0. Any bounce back restarts the count.
- Events are registered and asserted for exactly one cycle:
  - press <= (cnt == COUNT_MAX) & s2 & ~level.
  - release <= (cnt == COUNT_MAX) & ~s2 & level.
- Hold counter, per edge:
  - if level == 0: hold <= 0.
  - else if hold != LONG_MAX: hold <= hold+1. It saturates at LONG_MAX.
  - long_press <= level & (hold == LONG_MAX-1). This fires once per press.
- A release before LONG_MAX cycles produces no long_press. A release after long_press still pulses release.
- Reset values (asynchronous, on rst_n low): level, press, release and long_press are 0; cnt, hold, s1 and s2 are 0.
- Reset mid-operation clears all state immediately, with no pulse emitted. After reset deassertion, a still-pressed button is debounced again from scratch and produces a fresh press.

## Timing
- The input changes and is stable before edge E0:
  - s1 updates at E0, s2 at E1.
  - cnt counts from E2.
  - level toggles at E(COUNT_MAX+2).
- press or release is high during the cycle following E(COUNT_MAX+2), coincident with the first cycle of the new level.
- long_press is high during the cycle following E(COUNT_MAX+2+LONG_MAX), provided the press is held throughout.
- Simultaneous changes on several channels give same-cycle pulses on each.
- press and release are never high together on one channel.
- Minimum accepted pulse width is COUNT_MAX+1 cycles at s2. Anything shorter is filtered.

## Test plan
Use CHANNELS=2, COUNT_MAX=3, LONG_MAX=10, ACTIVE_LOW=1.
- Reset: rst_n=0 with button_in=2'b11 → all outputs 0. Release reset and hold 20 cycles → no pulses, level=2'b00.
- Clean press: button_in[0] 1→0 before E0 and held → level[0] rises at E5, press[0] high for exactly 1 cycle (after E5), channel 1 outputs stay 0.
- Bounce: button_in[0] low for 3 cycles, high 1 cycle, then low held → no change during the bounce. level[0] rises 5 edges after the final falling transition, with a single press pulse.
- Long press: hold channel 0 pressed → long_press[0] high for exactly one cycle after E15, and never again while held. Release → release[0] pulse 5 edges later, no further long_press.
- Simultaneous and short: press both channels together → press=2'b11 in the same cycle. Release channel 1 after 4 held cycles → release[1] pulse, no long_press[1]. Channel 0 unaffected.
- Reset mid-count: assert rst_n low 2 cycles into debounce of a press → outputs stay 0. Deassert with the button still pressed → press fires COUNT_MAX+2 edges after the first post-reset edge.

Source files
------------

// File: rtl/button_conditioner.sv
// Per-channel button conditioner: 2-flop sync, counter debounce, press/release/long-press pulses.
// Latency: COUNT_MAX+3 edges from a stable pin change to level/event outputs; no backpressure.
module button_conditioner #(
  parameter int CHANNELS   = 4,
  parameter int COUNT_MAX  = 19999,
  parameter int CNT_W      = 16,
  parameter int LONG_MAX   = 50000000,
  parameter int HOLD_W     = 26,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press
);

  localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(COUNT_MAX);
  localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(LONG_MAX);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_MAX - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic              p;
    logic              s1_q;
    logic              s2_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              lvl_q;
    logic              press_q;
    logic              rel_q;
    logic              long_q;
    logic              cnt_done;

    assign p        = (ACTIVE_LOW != 0) ? ~button_in[i] : button_in[i];
    assign cnt_done = (cnt_q == CNT_TOP);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        cnt_q   <= '0;
        hold_q  <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        s1_q <= p;
        s2_q <= s1_q;

        // Any sample agreeing with the current level restarts the count
        if (s2_q != lvl_q) begin
          if (cnt_done) begin
            lvl_q <= s2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end

        press_q <= cnt_done & s2_q & ~lvl_q;
        rel_q   <= cnt_done & ~s2_q & lvl_q;

        // Saturating hold counter makes long_press fire only once per press
        if (!lvl_q) begin
          hold_q <= '0;
        end else if (hold_q != HOLD_TOP) begin
          hold_q <= hold_q + 1'b1;
        end
        long_q <= lvl_q & (hold_q == HOLD_FIRE);
      end
    end

    assign level[i]         = lvl_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = rel_q;
    assign long_press[i]    = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: 2 channels, COUNT_MAX=3, LONG_MAX=10, active-low pins.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] rel;
  logic [1:0] lp;

  int n_cmp;
  int n_err;

  button_conditioner #(
    .CHANNELS  (2),
    .COUNT_MAX (3),
    .CNT_W     (16),
    .LONG_MAX  (10),
    .HOLD_W    (26),
    .ACTIVE_LOW(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_in    (btn),
    .level        (level),
    .press        (press),
    .release_pulse(rel),
    .long_press   (lp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0;
    btn   = 2'b11;
    #1;
    got = {level, press, rel, lp};
    n_cmp++;
    if (got !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async got=%b exp=%b", got, 8'h00);
    end
    tick();
    tick();
    got = {level, press, rel, lp};
    n_cmp++;
    if (got !== 8'h00) begin
      n_err++;
      $display("FAIL reset_held got=%b exp=%b", got, 8'h00);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== 8'h00) begin
        n_err++;
        $display("FAIL reset_idle k=%0d got=%b exp=%b", k, got, 8'h00);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] got, exp;
    btn = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b0, 1'(k >= 6), 1'b0, 1'(k == 6), 4'b0000};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL clean_press k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    btn = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b0, 1'(k < 6), 2'b00, 1'b0, 1'(k == 6), 2'b00};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL clean_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Low 3 cycles, high 1, low held: count reaches COUNT_MAX but bounce resets it.
  task automatic test_bounce();
    logic [7:0] got, exp;
    btn = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== 8'h00) begin
        n_err++;
        $display("FAIL bounce_early k=%0d got=%b exp=%b", k, got, 8'h00);
      end
      if (k == 3) btn = 2'b11;
      if (k == 4) btn = 2'b10;
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b0, 1'(k >= 6), 1'b0, 1'(k == 6), 4'b0000};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL bounce_settle k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    btn = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b0, 1'(k < 6), 2'b00, 1'b0, 1'(k == 6), 2'b00};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL bounce_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_long_press();
    logic [7:0] got, exp;
    btn = 2'b10;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp = {1'b0, 1'(k >= 6), 1'b0, 1'(k == 6), 2'b00, 1'b0, 1'(k == 16)};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL long_hold k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    btn = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b0, 1'(k < 6), 2'b00, 1'b0, 1'(k == 6), 2'b00};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL long_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // Both pressed together; channel 1 raw-pressed for exactly COUNT_MAX+1 cycles.
  task automatic test_simultaneous();
    logic [7:0] got, exp;
    btn = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = {1'(k >= 6 && k <= 9), 1'(k >= 6),
             (k == 6) ? 2'b11 : 2'b00,
             (k == 10) ? 2'b10 : 2'b00,
             (k == 16) ? 2'b01 : 2'b00};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL simul k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 4) btn = 2'b10;
    end
    btn = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b0, 1'(k < 6), 2'b00, 1'b0, 1'(k == 6), 2'b00};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL simul_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp;
    btn = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== 8'h00) begin
        n_err++;
        $display("FAIL rmid_pre k=%0d got=%b exp=%b", k, got, 8'h00);
      end
    end
    rst_n = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) tick();
      else #1;
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== 8'h00) begin
        n_err++;
        $display("FAIL rmid_in_reset k=%0d got=%b exp=%b", k, got, 8'h00);
      end
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b0, 1'(k >= 6), 1'b0, 1'(k == 6), 4'b0000};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rmid_post k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    btn = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {1'b0, 1'(k < 6), 2'b00, 1'b0, 1'(k == 6), 2'b00};
      got = {level, press, rel, lp};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rmid_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    btn   = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
